// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci display path: conversion FSM
// states, BCD geometry and the active-low 7-segment glyph table.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } fsm_state_e;

    localparam int N_BCD = 5;
    localparam int BIN_W = 16;
    localparam int BCD_W = 4 * N_BCD;
    localparam int SR_W  = BCD_W + BIN_W;

    // Active-low segments: [7:1] = a..g, [0] = dp (kept off).
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_LUT [10] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
    };

    // Glyph for one BCD nibble; anything outside 0..9 shows dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (nib == 4'(i)) seg = SEG_LUT[i];
        end
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16-bit binary to 5 BCD digits in
// 18 cycles from strobe to visible result, with a one-deep pending slot.
//
// Handshake: f_valid is a one-cycle strobe with no ready; the producer is
// never stalled. A strobe while busy lands in the pending slot, and a newer
// strobe overwrites an older pending value. bcd only changes in COMMIT, so
// downstream logic never sees a half-converted value.
module bin2bcd_seq
    import fib_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [BIN_W-1:0]  f_out,
    output logic              busy,
    output logic [BCD_W-1:0]  bcd
);

    fsm_state_e         state;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_next;
    logic [3:0]         iter;
    logic               pend;
    logic [BIN_W-1:0]   pend_val;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] cur);
        logic [SR_W-1:0] adj;
        logic [3:0]      nib;
        adj = cur;
        for (int k = 0; k < N_BCD; k++) begin
            nib = cur[BIN_W + 4*k +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            adj[BIN_W + 4*k +: 4] = nib;
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    // Next shift-register value for the current iteration.
    always_comb begin
        sr_next = dabble_step(sr);
    end

    // Conversion FSM, pending slot and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            iter     <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
            busy     <= 1'b0;
            bcd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_valid) begin
                        sr    <= {{BCD_W{1'b0}}, f_out};
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sr   <= sr_next;
                    iter <= iter + 4'd1;
                    if (f_valid) begin
                        pend     <= 1'b1;
                        pend_val <= f_out;
                    end
                    if (iter == 4'd15) state <= COMMIT;
                end
                COMMIT: begin
                    bcd  <= sr[SR_W-1:BIN_W];
                    iter <= '0;
                    if (pend) begin
                        // Start on the stored value; a strobe arriving now
                        // becomes the new pending value.
                        sr    <= {{BCD_W{1'b0}}, pend_val};
                        state <= CONV;
                        if (f_valid) pend_val <= f_out;
                        else         pend     <= 1'b0;
                    end else if (f_valid) begin
                        // Equivalent to parking it in pending and consuming it at once.
                        sr    <= {{BCD_W{1'b0}}, f_out};
                        state <= CONV;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fib_display.sv
// Fibonacci term display: converts each strobed 16-bit term to BCD and
// scan-multiplexes the 5 digits onto an N_AN-digit common-anode display.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits
// (digit 0 always shows); without it all 5 digits show, zeros included.
module fib_display
    import fib_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100000,
    parameter int N_AN         = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [BIN_W-1:0]  f_out,
    output logic              busy,
    output logic [BCD_W-1:0]  bcd,
    output logic [N_AN-1:0]   an,
    output logic [7:0]        dec_ddp
);

    localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int IDX_W = (N_AN > 1) ? $clog2(N_AN) : 1;

    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] digit_idx;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .f_valid (f_valid),
        .f_out   (f_out),
        .busy    (busy),
        .bcd     (bcd)
    );

    // Free-running scan timer; each wrap advances to the next anode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == CNT_W'(DIGIT_PERIOD - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_W'(N_AN - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    // One-hot-low anode for the digit being lit.
    always_comb begin
        an = ~(N_AN'(1) << digit_idx);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_BCD-1:0] lead_zero;

    // Digit k (k >= 1) is a leading zero when it and all higher digits are 0.
    always_comb begin
        lead_zero[0] = 1'b0;
        for (int k = 1; k < N_BCD; k++) begin
            lead_zero[k] = ((bcd >> (4*k)) == '0);
        end
    end
`endif

    // Segment pattern for the selected digit; positions past the BCD width stay dark.
    always_comb begin
        dec_ddp = SEG_BLANK;
        for (int k = 0; k < N_BCD; k++) begin
            if (int'(digit_idx) == k) begin
`ifdef LEADING_ZERO_BLANK_EN
                dec_ddp = lead_zero[k] ? SEG_BLANK : seg_decode(bcd[4*k +: 4]);
`else
                dec_ddp = seg_decode(bcd[4*k +: 4]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_fib_display.sv
// Self-checking bench for fib_display with DIGIT_PERIOD = 4, N_AN = 8.
module tb_fib_display;

  localparam int DP = 4;
  localparam int NA = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_valid = 1'b0;
  logic [15:0] f_out = '0;
  logic        busy;
  logic [19:0] bcd;
  logic [NA-1:0] an;
  logic [7:0]  dec_ddp;

  int checks = 0;
  int failures = 0;
  int cyc;

  typedef struct {
    int unsigned val;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [19:0] exp_q[$];

  fib_display #(.DIGIT_PERIOD(DP), .N_AN(NA)) dut (
    .clk     (clk),
    .rst     (rst),
    .f_valid (f_valid),
    .f_out   (f_out),
    .busy    (busy),
    .bcd     (bcd),
    .an      (an),
    .dec_ddp (dec_ddp)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic int pow10(int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] model_bcd(int v);
    logic [19:0] r = '0;
    for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [7:0] glyph(int d);
    case (d)
      0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
      4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
      8: return 8'h01;  9: return 8'h09;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(int v, int idx);
    if (idx >= 5) return 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx >= 1 && v < pow10(idx)) return 8'hFF;
`endif
    return glyph((v / pow10(idx)) % 10);
  endfunction

  // driver / checker tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic ok;
    @(negedge clk);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) if (bcd[4*k +: 4] > 4'd9) ok = 1'b0;
    check("bcd_nibble_legal", 32'(ok), 32'd1);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int unsigned v);
    f_valid = 1'b1;
    f_out   = 16'(v);
    tick();
    f_valid = 1'b0;
  endtask

  task automatic sweep(input int v, input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      tick();
      idx = (cyc / DP) % NA;
      check("scan_an", 32'(an), 32'(8'hFF ^ (8'd1 << idx)));
      check("scan_seg", 32'(dec_ddp), 32'(model_seg(v, idx)));
    end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy === 1'b1 && i < budget) begin
      tick();
      i++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_one(input int unsigned v, input logic [19:0] exp, input logic [19:0] prev);
    strobe(v);                                       // now in T+1
    check("busy_rise", 32'(busy), 32'd1);
    wait_n(16);                                      // T+17
    check("bcd_hold", 32'(bcd), 32'(prev));
    check("busy_hold", 32'(busy), 32'd1);
    tick();                                          // T+18
    check("bcd_result", 32'(bcd), 32'(exp));
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  logic [19:0] prev;
  int unsigned rv;
  logic seen21;

  initial begin
    vecs[0] = '{46368, 20'h46368};
    vecs[1] = '{65535, 20'h65535};
    vecs[2] = '{0,     20'h00000};
    vecs[3] = '{5,     20'h00005};
    vecs[4] = '{233,   20'h00233};
    vecs[5] = '{9999,  20'h09999};
    vecs[6] = '{10000, 20'h10000};
    vecs[7] = '{1597,  20'h01597};
    vecs[8] = '{99,    20'h00099};
    vecs[9] = '{7,     20'h00007};

    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_an", 32'(an), 32'hFE);
    check("rst_seg", 32'(dec_ddp), 32'h03);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // idle scan across two full anode rotations
    sweep(0, 2 * NA * DP);

    // table-driven conversions, each followed by a full display rotation
    prev = '0;
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].val, vecs[i].exp, prev);
      prev = vecs[i].exp;
      sweep(int'(vecs[i].val), NA * DP);
    end

    // back-to-back: 13 at T, 21 at T+3, 34 at T+5; 21 is overwritten
    seen21 = 1'b0;
    strobe(13);                                      // T+1
    wait_n(2);                                       // T+3
    strobe(21);                                      // T+4
    tick();                                          // T+5
    strobe(34);                                      // T+6
    for (int i = 0; i < 12; i++) begin tick(); if (bcd == 20'h00021) seen21 = 1'b1; end
    check("b2b_first", 32'(bcd), 32'h00013);
    check("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin tick(); if (bcd == 20'h00021) seen21 = 1'b1; end
    check("b2b_hold", 32'(bcd), 32'h00013);
    tick();                                          // T+35
    check("b2b_second", 32'(bcd), 32'h00034);
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_dropped", 32'(seen21), 32'd0);

    // strobe during the last iteration, then another during COMMIT
    strobe(100);                                     // T+1
    wait_n(15);                                      // T+16
    strobe(200);                                     // T+17
    strobe(300);                                     // T+18
    check("col_a", 32'(bcd), 32'h00100);
    wait_n(16);                                      // T+34
    check("col_a_hold", 32'(bcd), 32'h00100);
    tick();                                          // T+35
    check("col_b", 32'(bcd), 32'h00200);
    check("col_b_busy", 32'(busy), 32'd1);
    wait_n(17);                                      // T+52
    check("col_c", 32'(bcd), 32'h00300);
    check("col_c_idle", 32'(busy), 32'd0);
    prev = 20'h00300;

    // randomized conversions against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      wait_n($urandom_range(0, 5));
      rv = $urandom_range(0, 65535);
      exp_q.push_back(model_bcd(int'(rv)));
      strobe(rv);
      wait_n(16);
      check("rand_hold", 32'(bcd), 32'(prev));
      tick();
      prev = exp_q.pop_front();
      check("rand_bcd", 32'(bcd), 32'(prev));
      wait_idle(40);
    end

    // reset in iteration 8 of converting 1597 with a value pending
    run_one(4181, 20'h04181, prev);
    strobe(1597);                                    // T+1
    wait_n(4);                                       // T+5
    strobe(777);                                     // T+6, goes to pending
    wait_n(3);                                       // T+9, iteration 8
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_an", 32'(an), 32'hFE);
    check("abort_seg", 32'(dec_ddp), 32'h03);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("abort_no_busy", 32'(busy), 32'd0);
      check("abort_no_commit", 32'(bcd), 32'd0);
    end
    run_one(21, 20'h00021, 20'h00000);
    sweep(21, NA * DP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_display.md
Name: fib_display

Overview:
- Downstream consumer of the Fibonacci generator. It takes each valid 16-bit term (f_valid/f_out) and converts it to 5 BCD digits with a sequential double-dabble engine.
- It then scan-multiplexes the digits onto the board's 8-digit common-anode 7-segment display.
- It sits between the generator and the top-level display pins.

Parameters:
- DIGIT_PERIOD, 100000, clk cycles each digit stays lit (1 ms at 100 MHz); minimum 2.
- N_AN, 8, number of anode lines driven; digits 5..N_AN-1 are always blanked.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- f_valid  in  1  one-cycle strobe; f_out is valid this cycle
- f_out  in  16  unsigned binary value to display
- busy  out  1  high while a conversion is in progress
- bcd  out  20  last completed conversion, 5 digits, [3:0] = units
- an  out  N_AN  anode enables, active low, one-hot-low
- dec_ddp  out  8  segments, active low; [7:1] = a..g, [0] = dp (dp always 1/off)

Behaviour:
- Reset (async, immediate) puts the block in this state:
  - FSM = IDLE, busy = 0, bcd = 0, pending flag = 0.
  - Scan counter = 0, digit index = 0.
  - an = all ones except bit0 = 0.
  - dec_ddp = 8'b0000_0011 (glyph '0').
- Conversion FSM:
  - IDLE: on f_valid, load shift register {20'b0, f_out}, iter = 0, go to CONV; busy = 1 from the next cycle.
  - CONV: one iteration per cycle. Each BCD nibble >= 5 gets +3, then the whole 36-bit register shifts left by 1. After iter == 15, go to COMMIT.
  - COMMIT: bcd <= upper 20 bits. If pending is set, load the pending value, clear pending and go to CONV. Otherwise go to IDLE with busy = 0.
- Latency: f_valid in cycle T gives the new bcd value visible in cycle T+18 (1 load + 16 iterations + 1 commit).
- f_valid during CONV/COMMIT: the value is stored in a one-deep pending register. A newer value overwrites an older pending one; intermediate values are dropped. No backpressure to the generator.
- f_valid in the same cycle COMMIT consumes pending: the new value replaces the pending value and sets pending again.
- Arithmetic: values 0..65535 are all legal; 65535 gives bcd 6_5_5_3_5. The bcd output changes only in COMMIT, so the display never shows a partial conversion.
- Scan:
  - The counter counts 0..DIGIT_PERIOD-1 and wraps.
  - On wrap, the digit index increments modulo N_AN.
  - an = ~(1 << index).
  - Index 0..4 selects the matching bcd nibble; index >= 5 gives dec_ddp = 8'hFF (blank).
  - The scan runs continuously and independently of the FSM.
- Segment decode covers nibble values 0..9 only; an illegal nibble displays blank.
- Reset mid-conversion aborts the conversion and discards the pending value; bcd returns to 0.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined: a nibble at index k (1..4) is blanked (dec_ddp = 8'hFF, anode still pulses) if it and every higher nibble are 0. Digit 0 always shows. Example: 233 shows "233" with digits 3,4 dark.
- Not defined: all 5 digits always show, including leading zeros ("00233").

Decomposition:
- Shared package fib_pkg contains:
  - FSM state enum (IDLE, CONV, COMMIT).
  - N_BCD = 5.
  - 7-segment lookup constant for 0..9 plus SEG_BLANK = 8'hFF.
- One natural sub-module, bin2bcd_seq: the FSM, pending register and double-dabble engine, with ports clk, rst, f_valid, f_out, busy, bcd.
- The top level holds the scan counter, anode generation and segment decode.

Test Plan:
- Reset release, no input: bcd = 0, busy = 0; an cycles FE→FD→…→7F with each step exactly DIGIT_PERIOD cycles (use DIGIT_PERIOD=4); dec_ddp = 03 on index 0.
- f_valid with f_out = 46368 at cycle T: busy rises at T+1, bcd = 20'h46368 at T+18, busy = 0 at T+18.
- Back-to-back strobes: 13 at T, 21 at T+3, 34 at T+5. Result: bcd = 13 at T+18, then 34 at T+35; 21 is never shown.
- f_out = 65535, then f_out = 0: bcd = 20'h65535, then 20'h00000; no nibble exceeds 9 at any cycle.
- Leading-zero feature: with f_out = 5 and LEADING_ZERO_BLANK_EN defined, indices 1..4 give dec_ddp = FF and index 0 gives the '5' glyph. Without the macro, indices 1..4 give 03.
- Assert rst at iteration 8 of converting 1597: busy = 0 and bcd = 0 immediately, pending is cleared, and no later COMMIT occurs.
